uart_mlc2: RTL and testbench

UART command decoder driving four trigger channels and one 8-bit control value. It receives 8N1 serial frames at 9600 baud from a 12 MHz clock and parses fixed-length command packets. It stores per-channel configuration, fires trigger pulse bursts on command, and acknowledges each complete packet on a serial transmit line. It sits between the host serial link and the channel trigger and voltage-control logic.

---
 rtl/uart_mlc2.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_uart_mlc2.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_mlc2.sv
// uart_mlc2: serial command decoder. Receives 8N1 bytes, parses set/trigger
// packets, holds per-channel burst configuration, fires trigger bursts and
// answers each complete packet with a one-byte acknowledge on tx.
module uart_mlc2 #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int TRIG_HIGH    = 12,
    parameter int TRIG_LOW     = 12,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx,
    output logic       tx,
    output logic       txD,
    output logic       trigout_ch0,
    output logic       trigout_ch1,
    output logic       trigout_ch2,
    output logic       trigout_ch3,
    output logic [7:0] vctrout_ch0
);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
    localparam logic [7:0]  HIGH_LAST = 8'(TRIG_HIGH - 1);
    localparam logic [7:0]  LOW_LAST  = 8'(TRIG_LOW - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_S_CH, P_S_CNT, P_S_VAL, P_T_CH} p_state_t;
    typedef enum logic {T_IDLE, T_BUSY} tx_state_t;

    logic rx_meta, rx_sync, rx_prev;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end
    assign txD = rx_sync;

    rx_state_t   rx_state_reg, rx_state_next;
    logic [15:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]  rx_bit_reg, rx_bit_next;
    logic [7:0]  rx_shift_reg, rx_shift_next;
    logic        byte_stb_reg, byte_stb_next;
    logic        frame_err_reg, frame_err_next;

    // Receiver state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_state_reg  <= R_IDLE;
            rx_cnt_reg    <= '0;
            rx_bit_reg    <= '0;
            rx_shift_reg  <= '0;
            byte_stb_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rx_state_reg  <= rx_state_next;
            rx_cnt_reg    <= rx_cnt_next;
            rx_bit_reg    <= rx_bit_next;
            rx_shift_reg  <= rx_shift_next;
            byte_stb_reg  <= byte_stb_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Receiver next state: start re-check at half bit, then bit-centre samples
    always_comb begin
        rx_state_next  = rx_state_reg;
        rx_cnt_next    = rx_cnt_reg + 16'd1;
        rx_bit_next    = rx_bit_reg;
        rx_shift_next  = rx_shift_reg;
        byte_stb_next  = 1'b0;
        frame_err_next = 1'b0;
        case (rx_state_reg)
            R_IDLE: begin
                rx_cnt_next = '0;
                if (rx_prev && !rx_sync) rx_state_next = R_START;
            end
            R_START: if (rx_cnt_reg == HALF_LAST) begin
                rx_cnt_next   = '0;
                rx_bit_next   = '0;
                rx_state_next = rx_sync ? R_IDLE : R_DATA;
            end
            R_DATA: if (rx_cnt_reg == BIT_LAST) begin
                rx_cnt_next   = '0;
                rx_shift_next = {rx_sync, rx_shift_reg[7:1]};
                rx_bit_next   = rx_bit_reg + 3'd1;
                if (rx_bit_reg == 3'd7) rx_state_next = R_STOP;
            end
            R_STOP: if (rx_cnt_reg == BIT_LAST) begin
                rx_cnt_next    = '0;
                rx_state_next  = R_IDLE;
                byte_stb_next  = rx_sync;
                frame_err_next = !rx_sync;
            end
            default: rx_state_next = R_IDLE;
        endcase
    end

    p_state_t    p_state_reg, p_state_next;
    logic [1:0]  ch_reg, ch_next;
    logic        bad_reg, bad_next;
    logic [7:0]  count_reg, count_next;
    logic [31:0] tmo_reg, tmo_next;
    logic        cfg_we, ack_req;
    logic [7:0]  ack_data;
    logic [3:0]  fire;

    // Parser state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            p_state_reg <= P_IDLE;
            ch_reg      <= '0;
            bad_reg     <= 1'b0;
            count_reg   <= '0;
            tmo_reg     <= '0;
        end else begin
            p_state_reg <= p_state_next;
            ch_reg      <= ch_next;
            bad_reg     <= bad_next;
            count_reg   <= count_next;
            tmo_reg     <= tmo_next;
        end
    end

    // Parser next state; a byte strobe wins over a coincident timeout
    always_comb begin
        p_state_next = p_state_reg;
        ch_next      = ch_reg;
        bad_next     = bad_reg;
        count_next   = count_reg;
        tmo_next     = tmo_reg;
        cfg_we       = 1'b0;
        ack_req      = 1'b0;
        ack_data     = 8'h00;
        fire         = 4'b0000;
        if (frame_err_reg) begin
            p_state_next = P_IDLE;
            tmo_next     = '0;
        end else if (byte_stb_reg) begin
            tmo_next = '0;
            case (p_state_reg)
                P_IDLE: begin
                    if (rx_shift_reg == 8'h53)      p_state_next = P_S_CH;
                    else if (rx_shift_reg == 8'h5C) p_state_next = P_T_CH;
                end
                P_S_CH: begin
                    ch_next      = rx_shift_reg[1:0];
                    bad_next     = (rx_shift_reg > 8'd3);
                    p_state_next = P_S_CNT;
                end
                P_S_CNT: begin
                    count_next   = rx_shift_reg;
                    p_state_next = P_S_VAL;
                end
                P_S_VAL: begin
                    p_state_next = P_IDLE;
                    ack_req      = 1'b1;
                    if (!bad_reg) begin
                        cfg_we   = 1'b1;
                        ack_data = 8'hA5;
                    end
                end
                P_T_CH: begin
                    p_state_next = P_IDLE;
                    ack_req      = 1'b1;
                    if (rx_shift_reg <= 8'd3) begin
                        fire     = 4'b0001 << rx_shift_reg[1:0];
                        ack_data = 8'hA5;
                    end
                end
                default: p_state_next = P_IDLE;
            endcase
        end else if (p_state_reg != P_IDLE) begin
            if (tmo_reg == TMO_LAST) begin
                p_state_next = P_IDLE;
                tmo_next     = '0;
            end else begin
                tmo_next = tmo_reg + 32'd1;
            end
        end
    end

    logic [7:0] cfg_cnt [4];
    logic [7:0] cfg_val [4];

    // Configuration store, written when a good set packet completes
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 4; i++) begin
                cfg_cnt[i] <= '0;
                cfg_val[i] <= '0;
            end
        end else if (cfg_we) begin
            cfg_cnt[ch_reg] <= count_reg;
            cfg_val[ch_reg] <= rx_shift_reg;
        end
    end
    assign vctrout_ch0 = cfg_val[0];

    logic [3:0] trig;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ch
            logic       active_reg, high_reg;
            logic [7:0] left_reg, phase_reg;

            // Burst engine: latches the count at fire time, ignores fires while running
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    active_reg <= 1'b0;
                    high_reg   <= 1'b0;
                    left_reg   <= '0;
                    phase_reg  <= '0;
                end else if (!active_reg) begin
                    if (fire[gi] && cfg_cnt[gi] != 8'd0) begin
                        active_reg <= 1'b1;
                        high_reg   <= 1'b1;
                        left_reg   <= cfg_cnt[gi];
                        phase_reg  <= '0;
                    end
                end else if (high_reg) begin
                    if (phase_reg == HIGH_LAST) begin
                        high_reg  <= 1'b0;
                        phase_reg <= '0;
                        left_reg  <= left_reg - 8'd1;
                    end else begin
                        phase_reg <= phase_reg + 8'd1;
                    end
                end else if (phase_reg == LOW_LAST) begin
                    phase_reg <= '0;
                    if (left_reg == 8'd0) active_reg <= 1'b0;
                    else                  high_reg   <= 1'b1;
                end else begin
                    phase_reg <= phase_reg + 8'd1;
                end
            end
            assign trig[gi] = high_reg;
        end
    endgenerate

    assign trigout_ch0 = trig[0];
    assign trigout_ch1 = trig[1];
    assign trigout_ch2 = trig[2];
    assign trigout_ch3 = trig[3];

    tx_state_t   tx_state_reg, tx_state_next;
    logic        tx_reg, tx_next;
    logic [8:0]  tx_shift_reg, tx_shift_next;
    logic [3:0]  tx_bit_reg, tx_bit_next;
    logic [15:0] tx_cnt_reg, tx_cnt_next;

    // Transmitter state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx_state_reg <= T_IDLE;
            tx_reg       <= 1'b1;
            tx_shift_reg <= '1;
            tx_bit_reg   <= '0;
            tx_cnt_reg   <= '0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_reg       <= tx_next;
            tx_shift_reg <= tx_shift_next;
            tx_bit_reg   <= tx_bit_next;
            tx_cnt_reg   <= tx_cnt_next;
        end
    end

    // Transmitter next state; requests arriving while busy are dropped
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_next       = tx_reg;
        tx_shift_next = tx_shift_reg;
        tx_bit_next   = tx_bit_reg;
        tx_cnt_next   = tx_cnt_reg + 16'd1;
        case (tx_state_reg)
            T_IDLE: begin
                tx_cnt_next = '0;
                if (ack_req) begin
                    tx_state_next = T_BUSY;
                    tx_next       = 1'b0;
                    tx_shift_next = {1'b1, ack_data};
                    tx_bit_next   = '0;
                end
            end
            T_BUSY: if (tx_cnt_reg == BIT_LAST) begin
                tx_cnt_next = '0;
                if (tx_bit_reg == 4'd9) begin
                    tx_state_next = T_IDLE;
                end else begin
                    tx_next       = tx_shift_reg[0];
                    tx_shift_next = {1'b1, tx_shift_reg[8:1]};
                    tx_bit_next   = tx_bit_reg + 4'd1;
                end
            end
            default: tx_state_next = T_IDLE;
        endcase
    end
    assign tx = tx_reg;

endmodule

// File: tb/tb_uart_mlc2.sv
// Bench for uart_mlc2: table of serial packets with expected register value,
// acknowledge count/value and per-channel pulse counts, plus hand sequences
// for burst overlap, reconfiguration during a burst and reset mid-burst.
`timescale 1ns/1ps
module tb_uart_mlc2;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       rx = 1'b1;
    logic       tx, txD, t0, t1, t2, t3;
    logic [7:0] vctr;
    logic [3:0] trig;

    uart_mlc2 #(.CLKS_PER_BIT(CPB), .TRIG_HIGH(12), .TRIG_LOW(12), .TIMEOUT_BITS(32)) dut (
        .clk(clk), .nrst(nrst), .rx(rx), .tx(tx), .txD(txD),
        .trigout_ch0(t0), .trigout_ch1(t1), .trigout_ch2(t2), .trigout_ch3(t3),
        .vctrout_ch0(vctr)
    );

    always #5 clk = ~clk;
    assign trig = {t3, t2, t1, t0};

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse monitor: counts rising edges and flags highs not exactly 12 clocks wide
    int pulse_total [4] = '{default: 0};
    int hi_len [4] = '{default: 0};
    int width_err = 0;
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (!nrst) begin
                hi_len[c] = 0;
            end else if (trig[c]) begin
                if (hi_len[c] == 0) pulse_total[c]++;
                hi_len[c]++;
            end else begin
                if (hi_len[c] != 0 && hi_len[c] != 12) width_err++;
                hi_len[c] = 0;
            end
        end
    end

    // Acknowledge monitor: decodes each 8N1 frame seen on tx
    int         ack_total = 0;
    logic [7:0] ack_last = 8'h00;
    initial begin
        logic [7:0] d;
        forever begin
            @(negedge tx);
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                d[i] = tx;
            end
            ack_total++;
            ack_last = d;
            repeat (CPB) @(negedge clk);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic bad_stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = !bad_stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (bad_stop) repeat (2 * CPB) @(negedge clk);
    endtask

    typedef struct {
        logic [0:5][7:0] b;
        int              n;
        logic [5:0]      bad_stop;
        int              gap_idx;
        int              gap_clks;
        logic [7:0]      exp_vctr;
        int              exp_acks;
        logic [7:0]      exp_ack;
        logic [3:0][7:0] exp_p;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    int a0;
    int p0 [4];

    task automatic snap();
        a0 = ack_total;
        for (int c = 0; c < 4; c++) p0[c] = pulse_total[c];
    endtask

    initial begin
        vecs[0]  = '{48'h530001030000, 4, 6'b0, -1, 0, 8'h03, 1, 8'hA5, 32'h00000000};
        vecs[1]  = '{48'h5C0000000000, 2, 6'b0, -1, 0, 8'h03, 1, 8'hA5, 32'h00000001};
        vecs[2]  = '{48'h530000000000, 4, 6'b0, -1, 0, 8'h00, 1, 8'hA5, 32'h00000000};
        vecs[3]  = '{48'h5C0000000000, 2, 6'b0, -1, 0, 8'h00, 1, 8'hA5, 32'h00000000};
        vecs[4]  = '{48'h530002150000, 4, 6'b0, -1, 0, 8'h15, 1, 8'hA5, 32'h00000000};
        vecs[5]  = '{48'h5C0000000000, 2, 6'b0, -1, 0, 8'h15, 1, 8'hA5, 32'h00000002};
        vecs[6]  = '{48'h000002150000, 4, 6'b0, -1, 0, 8'h15, 0, 8'h00, 32'h00000000};
        vecs[7]  = '{48'h530701030000, 4, 6'b0, -1, 0, 8'h15, 1, 8'h00, 32'h00000000};
        vecs[8]  = '{48'h5C0700000000, 2, 6'b0, -1, 0, 8'h15, 1, 8'h00, 32'h00000000};
        vecs[9]  = '{48'h530203AA0000, 4, 6'b0, -1, 0, 8'h15, 1, 8'hA5, 32'h00000000};
        vecs[10] = '{48'h5C0200000000, 2, 6'b0, -1, 0, 8'h15, 1, 8'hA5, 32'h00030000};
        vecs[11] = '{48'h530101770000, 4, 6'b0, -1, 0, 8'h15, 1, 8'hA5, 32'h00000000};
        vecs[12] = '{48'h5C0100000000, 2, 6'b0, -1, 0, 8'h15, 1, 8'hA5, 32'h00000100};
        vecs[13] = '{48'h5C0300000000, 2, 6'b0, -1, 0, 8'h15, 1, 8'hA5, 32'h00000000};
        vecs[14] = '{48'h5C0000000000, 2, 6'b000001, -1, 0, 8'h15, 0, 8'h00, 32'h00000000};
        vecs[15] = '{48'h5300055C0000, 5, 6'b000100, -1, 0, 8'h15, 1, 8'hA5, 32'h00000002};
        vecs[16] = '{48'h530001030000, 4, 6'b0, 1, 40 * CPB, 8'h15, 0, 8'h00, 32'h00000000};
        vecs[17] = '{48'h530005330000, 4, 6'b0, 1, 16 * CPB, 8'h33, 1, 8'hA5, 32'h00000000};

        // Reset state, during and after reset
        repeat (5) @(negedge clk);
        check("reset tx", tx, 1);
        check("reset txD", txD, 1);
        check("reset trig", trig, 0);
        check("reset vctr", vctr, 0);
        nrst = 1'b1;
        repeat (200) @(negedge clk);
        check("idle tx", tx, 1);
        check("idle trig", trig, 0);
        check("idle acks", ack_total, 0);

        for (int v = 0; v < NV; v++) begin
            snap();
            for (int i = 0; i < vecs[v].n; i++) begin
                send_byte(vecs[v].b[i], vecs[v].bad_stop[i]);
                if (i == vecs[v].gap_idx) repeat (vecs[v].gap_clks) @(negedge clk);
            end
            repeat (300) @(negedge clk);
            check($sformatf("v%0d vctr", v), vctr, vecs[v].exp_vctr);
            check($sformatf("v%0d acks", v), ack_total - a0, vecs[v].exp_acks);
            if (vecs[v].exp_acks > 0)
                check($sformatf("v%0d ack", v), ack_last, vecs[v].exp_ack);
            for (int c = 0; c < 4; c++)
                check($sformatf("v%0d pulses ch%0d", v, c), pulse_total[c] - p0[c],
                      int'(vecs[v].exp_p[c]));
            $display("vector %0d done: vctr=%02h acks=%0d", v, vctr, ack_total - a0);
        end

        // Fire during burst is ignored; reconfiguring does not alter the running burst
        snap();
        send_byte(8'h53, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'd40, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h5C, 1'b0); send_byte(8'h03, 1'b0);
        send_byte(8'h5C, 1'b0); send_byte(8'h03, 1'b0);
        send_byte(8'h53, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
        repeat (600) @(negedge clk);
        check("overlap acks", ack_total - a0, 4);
        check("overlap ch3 pulses", pulse_total[3] - p0[3], 40);
        check("overlap ch0 pulses", pulse_total[0] - p0[0], 0);
        check("overlap vctr", vctr, 8'h33);
        snap();
        send_byte(8'h5C, 1'b0); send_byte(8'h03, 1'b0);
        repeat (300) @(negedge clk);
        check("reconfig ch3 pulses", pulse_total[3] - p0[3], 1);
        check("reconfig ack", ack_last, 8'hA5);
        $display("overlap/reconfig sequence done");

        // Reset in the middle of a burst
        send_byte(8'h53, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'd40, 1'b0); send_byte(8'h00, 1'b0);
        repeat (300) @(negedge clk);
        send_byte(8'h5C, 1'b0); send_byte(8'h03, 1'b0);
        repeat (100) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check("midreset trig", trig, 0);
        check("midreset vctr", vctr, 0);
        check("midreset tx", tx, 1);
        check("midreset txD", txD, 1);
        repeat (5) @(negedge clk);
        nrst = 1'b1;
        repeat (200) @(negedge clk);
        snap();
        send_byte(8'h5C, 1'b0); send_byte(8'h00, 1'b0);
        repeat (300) @(negedge clk);
        send_byte(8'h5C, 1'b0); send_byte(8'h03, 1'b0);
        repeat (300) @(negedge clk);
        check("postreset acks", ack_total - a0, 2);
        check("postreset ack", ack_last, 8'hA5);
        check("postreset ch0 pulses", pulse_total[0] - p0[0], 0);
        check("postreset ch3 pulses", pulse_total[3] - p0[3], 0);
        $display("reset mid-burst sequence done");

        check("pulse width errors", width_err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always ends on its own
    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "time limit");
    end
endmodule
